// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one SRAM-like bus, one outstanding transaction.
// Data requests win by default; a grant streak counter keeps fetch from starving.
module mem_bus_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        grant_data;
    logic        addr_ok_sel;
    logic        data_ok_sel;
    logic        rdata_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            streak_q <= '0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        addr_ok_sel = 1'b0;
        data_ok_sel = 1'b0;
        rdata_sel   = 1'b0;
        m_req       = 1'b0;
        m_wr        = 1'b0;
        m_size      = '0;
        m_addr      = '0;
        m_wdata     = '0;
        grant_data  = d_req && (!i_req || (streak_q < STREAK_MAX));

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    owner_d  = OWN_DATA;
                    wr_d     = d_wr;
                    size_d   = d_size;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    // Streak only grows while fetch is actually being passed over.
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                    state_d  = ADDR;
                end else if (i_req) begin
                    owner_d  = OWN_FETCH;
                    wr_d     = 1'b0;
                    size_d   = 2'd2;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                m_req       = 1'b1;
                m_wr        = wr_q;
                m_size      = size_q;
                m_addr      = addr_q;
                m_wdata     = wdata_q;
                addr_ok_sel = m_addr_ok;
                // A response without address acceptance is stray and dropped.
                data_ok_sel = m_addr_ok && m_data_ok;
                rdata_sel   = m_addr_ok && m_data_ok;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        state_d = IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                data_ok_sel = m_data_ok;
                rdata_sel   = 1'b1;
                if (m_data_ok) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        i_addr_ok = addr_ok_sel && (owner_q == OWN_FETCH);
        i_data_ok = data_ok_sel && (owner_q == OWN_FETCH);
        i_rdata   = (rdata_sel && (owner_q == OWN_FETCH)) ? m_rdata : '0;
        d_addr_ok = addr_ok_sel && (owner_q == OWN_DATA);
        d_data_ok = data_ok_sel && (owner_q == OWN_DATA);
        d_rdata   = (rdata_sel && (owner_q == OWN_DATA)) ? m_rdata : '0;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the grant rules and response routing.
module tb_mem_bus_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance to the drive point of the next cycle; slave handshakes default low.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Randomized-run state: pending requests and the model's view of the bus.
    logic        i_pend, d_pend;
    logic [31:0] ri_addr, rd_addr, rd_wdata;
    logic        rd_wr;
    logic [1:0]  rd_size;
    int          phase_m, streak_m, addr_wait, data_wait;
    logic        own_d, same_cycle, resp_addr, resp_data, win_d;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata;
    logic        act_i, act_d, done_now;

    initial begin
        rstn = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_wr = 0; d_size = '0; d_addr = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;

        applyStimulus();
        applyStimulus();
        #1;
        checkBit("reset_m_req", m_req, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkBit("reset_i_addr_ok", i_addr_ok, 1'b0);
        checkBit("reset_d_data_ok", d_data_ok, 1'b0);
        checkOutput("reset_m_addr", m_addr, 32'h0);
        rstn = 1'b1;

        $display("[TB] single fetch");
        applyStimulus();
        i_req = 1; i_addr = 32'hBFC00000;
        #1;
        checkBit("fetch_c0_busy", busy, 1'b0);
        applyStimulus();
        m_addr_ok = 1;
        #1;
        checkBit("fetch_c1_m_req", m_req, 1'b1);
        checkOutput("fetch_c1_m_addr", m_addr, 32'hBFC00000);
        checkBit("fetch_c1_m_wr", m_wr, 1'b0);
        checkOutput("fetch_c1_m_size", 32'(m_size), 32'd2);
        checkBit("fetch_c1_i_addr_ok", i_addr_ok, 1'b1);
        checkBit("fetch_c1_d_addr_ok", d_addr_ok, 1'b0);
        applyStimulus();
        i_req = 0;
        m_data_ok = 1; m_rdata = 32'h3C010001;
        #1;
        checkBit("fetch_c2_m_req", m_req, 1'b0);
        checkBit("fetch_c2_i_data_ok", i_data_ok, 1'b1);
        checkOutput("fetch_c2_i_rdata", i_rdata, 32'h3C010001);
        checkBit("fetch_c2_d_data_ok", d_data_ok, 1'b0);
        checkOutput("fetch_c2_d_rdata", d_rdata, 32'h0);
        applyStimulus();
        #1;
        checkBit("fetch_c3_busy", busy, 1'b0);
        checkBit("fetch_c3_i_data_ok", i_data_ok, 1'b0);

        $display("[TB] reset mid-transaction");
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80000040;
        applyStimulus();
        m_addr_ok = 1;
        #1;
        checkBit("rst_c1_d_addr_ok", d_addr_ok, 1'b1);
        applyStimulus();
        d_req = 0;
        #1;
        checkBit("rst_c2_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        checkBit("rst_async_busy", busy, 1'b0);
        checkBit("rst_async_m_req", m_req, 1'b0);
        applyStimulus();
        rstn = 1'b1;
        m_data_ok = 1; m_rdata = 32'h12345678;
        #1;
        checkBit("rst_late_d_data_ok", d_data_ok, 1'b0);
        checkOutput("rst_late_d_rdata", d_rdata, 32'h0);
        checkBit("rst_late_m_req", m_req, 1'b0);
        applyStimulus();
        #1;
        checkBit("rst_after_busy", busy, 1'b0);

        $display("[TB] simultaneous requests");
        i_req = 1; i_addr = 32'hBFC00100;
        d_req = 1; d_wr = 1; d_size = 0; d_addr = 32'h80000010; d_wdata = 32'hDEADBEEF;
        applyStimulus();
        m_addr_ok = 1;
        #1;
        checkOutput("sim_m_addr", m_addr, 32'h80000010);
        checkBit("sim_m_wr", m_wr, 1'b1);
        checkOutput("sim_m_size", 32'(m_size), 32'd0);
        checkOutput("sim_m_wdata", m_wdata, 32'hDEADBEEF);
        checkBit("sim_d_addr_ok", d_addr_ok, 1'b1);
        checkBit("sim_i_addr_ok", i_addr_ok, 1'b0);
        applyStimulus();
        d_req = 0;
        m_data_ok = 1;
        #1;
        checkBit("sim_d_data_ok", d_data_ok, 1'b1);
        checkBit("sim_i_data_ok", i_data_ok, 1'b0);
        applyStimulus();
        #1;
        checkBit("sim_gap_busy", busy, 1'b0);
        checkBit("sim_gap_m_req", m_req, 1'b0);
        applyStimulus();
        m_addr_ok = 1;
        #1;
        checkOutput("sim_fetch_m_addr", m_addr, 32'hBFC00100);
        checkBit("sim_fetch_m_wr", m_wr, 1'b0);
        checkOutput("sim_fetch_m_size", 32'(m_size), 32'd2);
        checkOutput("sim_fetch_m_wdata", m_wdata, 32'h0);
        checkBit("sim_fetch_i_addr_ok", i_addr_ok, 1'b1);
        applyStimulus();
        i_req = 0;
        m_data_ok = 1; m_rdata = 32'hCAFE0001;
        #1;
        checkBit("sim_fetch_i_data_ok", i_data_ok, 1'b1);
        checkOutput("sim_fetch_i_rdata", i_rdata, 32'hCAFE0001);
        applyStimulus();

        $display("[TB] starvation guard");
        i_req = 1; i_addr = 32'hBFC00200;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80001000;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            m_addr_ok = 1;
            #1;
            checkBit("starve_m_req", m_req, 1'b1);
            checkOutput("starve_m_addr", m_addr, (k % 5 == 4) ? 32'hBFC00200 : 32'h80001000);
            checkBit("starve_i_addr_ok", i_addr_ok, (k % 5 == 4));
            applyStimulus();
            m_data_ok = 1;
            #1;
            checkBit("starve_d_data_ok", d_data_ok, (k % 5 != 4));
            applyStimulus();
            #1;
            checkBit("starve_gap_busy", busy, 1'b0);
            if (k == 9) begin
                i_req = 0;
                d_req = 0;
            end
        end

        $display("[TB] slow slave");
        d_req = 1; d_wr = 0; d_size = 1; d_addr = 32'h80000020;
        begin
            int aok_count;
            aok_count = 0;
            for (int w = 0; w < 3; w++) begin
                applyStimulus();
                d_addr = 32'h12345678;
                m_addr_ok = (w == 2);
                m_data_ok = (w == 1);
                #1;
                checkBit("slow_m_req", m_req, 1'b1);
                checkOutput("slow_m_addr", m_addr, 32'h80000020);
                checkBit("slow_stray_d_data_ok", d_data_ok, 1'b0);
                if (d_addr_ok) aok_count++;
            end
            applyStimulus();
            d_req = 0;
            m_data_ok = 1; m_rdata = 32'h0000BEEF;
            #1;
            if (d_addr_ok) aok_count++;
            checkOutput("slow_addr_ok_pulses", 32'(aok_count), 32'd1);
            checkBit("slow_d_data_ok", d_data_ok, 1'b1);
            checkOutput("slow_d_rdata", d_rdata, 32'h0000BEEF);
            checkOutput("slow_i_rdata", i_rdata, 32'h0);
        end
        applyStimulus();

        $display("[TB] same-cycle addr_ok/data_ok");
        i_req = 1; i_addr = 32'hBFC00300;
        applyStimulus();
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h24020005;
        #1;
        checkBit("same_i_addr_ok", i_addr_ok, 1'b1);
        checkBit("same_i_data_ok", i_data_ok, 1'b1);
        checkOutput("same_i_rdata", i_rdata, 32'h24020005);
        applyStimulus();
        i_req = 0;
        #1;
        checkBit("same_next_busy", busy, 1'b0);
        checkBit("same_next_m_req", m_req, 1'b0);

        $display("[TB] randomized run");
        i_pend = 0; d_pend = 0;
        ri_addr = '0; rd_addr = '0; rd_wdata = '0; rd_wr = 0; rd_size = '0;
        phase_m = 0; streak_m = 0; addr_wait = 0; data_wait = 0;
        own_d = 0; same_cycle = 0;
        exp_wr = 0; exp_size = '0; exp_addr = '0; exp_wdata = '0;
        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            if (!i_pend && $urandom_range(0, 99) < 40) begin
                i_pend = 1;
                ri_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 99) < 40) begin
                d_pend = 1;
                rd_wr = 1'($urandom_range(0, 1));
                rd_size = 2'($urandom_range(0, 2));
                rd_addr = $urandom;
                rd_wdata = $urandom;
            end
            i_req = i_pend;
            i_addr = i_pend ? ri_addr : $urandom;
            d_req = d_pend;
            d_wr = d_pend ? rd_wr : 1'($urandom_range(0, 1));
            d_size = d_pend ? rd_size : 2'($urandom_range(0, 3));
            d_addr = d_pend ? rd_addr : $urandom;
            d_wdata = d_pend ? rd_wdata : $urandom;
            m_rdata = $urandom;

            resp_addr = 0;
            resp_data = 0;
            if (phase_m == 0) begin
                resp_data = ($urandom_range(0, 9) == 0);
            end else if (phase_m == 1) begin
                if (addr_wait == 0) begin
                    resp_addr = 1;
                    resp_data = same_cycle;
                end else begin
                    resp_data = ($urandom_range(0, 3) == 0);
                end
            end else begin
                resp_data = (data_wait == 0);
            end
            m_addr_ok = resp_addr;
            m_data_ok = resp_data;
            #1;

            act_i = (phase_m != 0) && !own_d;
            act_d = (phase_m != 0) && own_d;
            done_now = (phase_m == 2 && resp_data) || (phase_m == 1 && resp_addr && resp_data);
            checkBit("rnd_busy", busy, (phase_m != 0));
            checkBit("rnd_m_req", m_req, (phase_m == 1));
            if (phase_m == 1) begin
                checkOutput("rnd_m_addr", m_addr, exp_addr);
                checkBit("rnd_m_wr", m_wr, exp_wr);
                checkOutput("rnd_m_size", 32'(m_size), 32'(exp_size));
                checkOutput("rnd_m_wdata", m_wdata, exp_wdata);
            end
            checkBit("rnd_i_addr_ok", i_addr_ok, act_i && phase_m == 1 && resp_addr);
            checkBit("rnd_d_addr_ok", d_addr_ok, act_d && phase_m == 1 && resp_addr);
            checkBit("rnd_i_data_ok", i_data_ok, act_i && done_now);
            checkBit("rnd_d_data_ok", d_data_ok, act_d && done_now);
            checkOutput("rnd_i_rdata", i_rdata,
                (act_i && (phase_m == 2 || (resp_addr && resp_data))) ? m_rdata : 32'h0);
            checkOutput("rnd_d_rdata", d_rdata,
                (act_d && (phase_m == 2 || (resp_addr && resp_data))) ? m_rdata : 32'h0);

            if (phase_m == 0) begin
                if (i_pend || d_pend) begin
                    win_d = d_pend && (!i_pend || streak_m < MAX_STREAK);
                    if (win_d) begin
                        streak_m = i_pend ? ((streak_m + 1 > MAX_STREAK) ? MAX_STREAK : streak_m + 1) : 0;
                        exp_wr = rd_wr; exp_size = rd_size;
                        exp_addr = rd_addr; exp_wdata = rd_wdata;
                    end else begin
                        streak_m = 0;
                        exp_wr = 0; exp_size = 2'd2;
                        exp_addr = ri_addr; exp_wdata = 32'h0;
                    end
                    own_d = win_d;
                    phase_m = 1;
                    addr_wait = $urandom_range(0, 2);
                    data_wait = $urandom_range(0, 2);
                    same_cycle = ($urandom_range(0, 4) == 0);
                end
            end else if (phase_m == 1) begin
                if (resp_addr) begin
                    if (own_d) d_pend = 0;
                    else i_pend = 0;
                    phase_m = resp_data ? 0 : 2;
                end else begin
                    addr_wait--;
                end
            end else begin
                if (resp_data) phase_m = 0;
                else data_wait--;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
